// File: rtl/uart_line_engine.sv
// UART line engine: drains RX FIFO bytes and emits TX bytes as raw echo,
// uppercase echo, or a buffered line editor that replays the line on CR.
module uart_line_engine #(
    parameter int LINE_DEPTH  = 64,
    parameter int LEN_W       = $clog2(LINE_DEPTH + 1),
    parameter bit BEL_ON_FULL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             uart_rx_ready,
    output logic             uart_rx_read,
    input  logic [7:0]       uart_rx_byte,
    input  logic             uart_tx_full,
    output logic             uart_tx_start,
    output logic [7:0]       uart_tx_data_in,
    output logic [LEN_W-1:0] line_len,
    output logic [15:0]      drop_cnt,
    output logic             busy
);

    // state   | meaning
    // IDLE    | latch mode, wait for an RX byte
    // RD_WAIT | pop strobe issued, FIFO presenting the byte
    // RD_CAP  | capture the RX byte
    // PROC    | classify byte, load the emit sequence
    // EMIT    | push one TX byte once the TX FIFO has room
    // GAP     | one idle cycle so the TX full flag can settle
    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_RD_CAP, S_PROC, S_EMIT, S_GAP
    } state_t;

    typedef enum logic [1:0] {
        PH_LIT, PH_BUF, PH_TRL, PH_DONE
    } phase_t;

    localparam int AW = $clog2(LINE_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(LINE_DEPTH);

    state_t            state, state_nxt;
    phase_t            phase, phase_nxt;
    logic [1:0]        mode_q, mode_nxt, mode_sel;
    logic [7:0]        rx_byte, rx_byte_nxt;
    logic [23:0]       lit_q, lit_nxt;
    logic [1:0]        lit_cnt, lit_cnt_nxt;
    logic              replay, replay_nxt;
    logic [LEN_W-1:0]  buf_idx, buf_idx_nxt;
    logic              trl_idx, trl_idx_nxt;
    logic [LEN_W-1:0]  line_len_nxt;
    logic [15:0]       drop_cnt_nxt;
    logic              rx_read_nxt, tx_start_nxt;
    logic [7:0]        tx_data_nxt, cur_byte;
    logic              buf_we;
    logic [7:0]        buf_mem [LINE_DEPTH];

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            phase           <= PH_DONE;
            mode_q          <= 2'd0;
            rx_byte         <= 8'h00;
            lit_q           <= 24'h0;
            lit_cnt         <= 2'd0;
            replay          <= 1'b0;
            buf_idx         <= '0;
            trl_idx         <= 1'b0;
            line_len        <= '0;
            drop_cnt        <= 16'h0;
            uart_rx_read    <= 1'b0;
            uart_tx_start   <= 1'b0;
            uart_tx_data_in <= 8'h00;
        end else begin
            state           <= state_nxt;
            phase           <= phase_nxt;
            mode_q          <= mode_nxt;
            rx_byte         <= rx_byte_nxt;
            lit_q           <= lit_nxt;
            lit_cnt         <= lit_cnt_nxt;
            replay          <= replay_nxt;
            buf_idx         <= buf_idx_nxt;
            trl_idx         <= trl_idx_nxt;
            line_len        <= line_len_nxt;
            drop_cnt        <= drop_cnt_nxt;
            uart_rx_read    <= rx_read_nxt;
            uart_tx_start   <= tx_start_nxt;
            uart_tx_data_in <= tx_data_nxt;
        end
    end

    // Line storage carries no reset; line_len alone defines valid contents.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[line_len[AW-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        case (phase)
            PH_LIT:  cur_byte = lit_q[23:16];
            PH_BUF:  cur_byte = buf_mem[buf_idx[AW-1:0]];
            PH_TRL:  cur_byte = trl_idx ? 8'h0A : 8'h0D;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        mode_nxt     = mode_q;
        mode_sel     = (mode == 2'd3) ? 2'd0 : mode;
        rx_byte_nxt  = rx_byte;
        lit_nxt      = lit_q;
        lit_cnt_nxt  = lit_cnt;
        replay_nxt   = replay;
        buf_idx_nxt  = buf_idx;
        trl_idx_nxt  = trl_idx;
        line_len_nxt = line_len;
        drop_cnt_nxt = drop_cnt;
        rx_read_nxt  = 1'b0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = uart_tx_data_in;
        buf_we       = 1'b0;

        case (state)
            S_IDLE: begin
                mode_nxt = mode_sel;
                if (mode_q == 2'd2 && mode_sel != 2'd2) begin
                    line_len_nxt = '0;
                end
                if (uart_rx_ready) begin
                    rx_read_nxt = 1'b1;
                    state_nxt   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_nxt = S_RD_CAP;
            S_RD_CAP: begin
                rx_byte_nxt = uart_rx_byte;
                state_nxt   = S_PROC;
            end
            S_PROC: begin
                phase_nxt   = PH_LIT;
                replay_nxt  = 1'b0;
                lit_cnt_nxt = 2'd0;
                lit_nxt     = 24'h0;
                case (mode_q)
                    2'd1: begin
                        lit_cnt_nxt = 2'd1;
                        lit_nxt     = (rx_byte >= 8'h61 && rx_byte <= 8'h7A) ?
                                      {rx_byte - 8'h20, 16'h0} : {rx_byte, 16'h0};
                    end
                    2'd2: begin
                        if (rx_byte >= 8'h20 && rx_byte <= 8'h7E) begin
                            if (line_len < DEPTH_L) begin
                                buf_we       = 1'b1;
                                line_len_nxt = line_len + LEN_W'(1);
                                lit_cnt_nxt  = 2'd1;
                                lit_nxt      = {rx_byte, 16'h0};
                            end else begin
                                if (drop_cnt != 16'hFFFF) begin
                                    drop_cnt_nxt = drop_cnt + 16'd1;
                                end
                                if (BEL_ON_FULL) begin
                                    lit_cnt_nxt = 2'd1;
                                    lit_nxt     = {8'h07, 16'h0};
                                end
                            end
                        end else if (rx_byte == 8'h08 || rx_byte == 8'h7F) begin
                            if (line_len != '0) begin
                                line_len_nxt = line_len - LEN_W'(1);
                                lit_cnt_nxt  = 2'd3;
                                lit_nxt      = {8'h08, 8'h20, 8'h08};
                            end
                        end else if (rx_byte == 8'h0D) begin
                            lit_cnt_nxt = 2'd2;
                            lit_nxt     = {8'h0D, 8'h0A, 8'h00};
                            replay_nxt  = 1'b1;
                        end
                    end
                    default: begin
                        lit_cnt_nxt = 2'd1;
                        lit_nxt     = {rx_byte, 16'h0};
                    end
                endcase
                state_nxt = (lit_cnt_nxt != 2'd0) ? S_EMIT : S_IDLE;
            end
            S_EMIT: begin
                if (!uart_tx_full) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = cur_byte;
                    state_nxt    = S_GAP;
                    case (phase)
                        PH_LIT: begin
                            lit_nxt     = {lit_q[15:0], 8'h00};
                            lit_cnt_nxt = lit_cnt - 2'd1;
                            if (lit_cnt == 2'd1) begin
                                if (!replay) begin
                                    phase_nxt = PH_DONE;
                                end else if (line_len != '0) begin
                                    phase_nxt   = PH_BUF;
                                    buf_idx_nxt = '0;
                                end else begin
                                    phase_nxt   = PH_TRL;
                                    trl_idx_nxt = 1'b0;
                                end
                            end
                        end
                        PH_BUF: begin
                            if (buf_idx + LEN_W'(1) < line_len) begin
                                buf_idx_nxt = buf_idx + LEN_W'(1);
                            end else begin
                                phase_nxt   = PH_TRL;
                                trl_idx_nxt = 1'b0;
                            end
                        end
                        PH_TRL: begin
                            if (!trl_idx) begin
                                trl_idx_nxt = 1'b1;
                            end else begin
                                phase_nxt    = PH_DONE;
                                line_len_nxt = '0;
                            end
                        end
                        default: phase_nxt = PH_DONE;
                    endcase
                end
            end
            S_GAP: state_nxt = (phase == PH_DONE) ? S_IDLE : S_EMIT;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_line_engine.sv
// Directed bench for uart_line_engine with a 4-byte line buffer, a modelled
// RX FIFO (data shown one cycle after pop) and a TX byte logger.
module tb_uart_line_engine;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          uart_rx_ready;
    logic          uart_rx_read;
    logic [7:0]    uart_rx_byte = 8'h00;
    logic          uart_tx_full = 1'b0;
    logic          uart_tx_start;
    logic [7:0]    uart_tx_data_in;
    logic [LW-1:0] line_len;
    logic [15:0]   drop_cnt;
    logic          busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] rx_mem [256];
    int rx_wr = 0;
    int rx_rd = 0;
    int rd_pulses = 0;
    int read_viol = 0;
    logic prev_read = 1'b0;

    logic [7:0] tx_log [$];
    int stall_viol = 0;
    int gap_viol = 0;
    logic prev_start = 1'b0;
    logic full_s = 1'b0;

    uart_line_engine #(.LINE_DEPTH(DEPTH), .BEL_ON_FULL(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mode            (mode),
        .uart_rx_ready   (uart_rx_ready),
        .uart_rx_read    (uart_rx_read),
        .uart_rx_byte    (uart_rx_byte),
        .uart_tx_full    (uart_tx_full),
        .uart_tx_start   (uart_tx_start),
        .uart_tx_data_in (uart_tx_data_in),
        .line_len        (line_len),
        .drop_cnt        (drop_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    assign uart_rx_ready = (rx_rd != rx_wr);

    always @(posedge clk) full_s <= uart_tx_full;

    // RX FIFO model and TX logger, both sampled on the falling edge.
    always @(negedge clk) begin
        if (uart_rx_read) begin
            if (prev_read) read_viol++;
            if (rx_rd != rx_wr) begin
                uart_rx_byte = rx_mem[rx_rd];
                rx_rd++;
            end
            rd_pulses++;
        end
        prev_read = uart_rx_read;
        if (uart_tx_start) begin
            tx_log.push_back(uart_tx_data_in);
            if (full_s) stall_viol++;
            if (prev_start) gap_viol++;
        end
        prev_start = uart_tx_start;
    end

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr++;
    endtask

    function automatic int first_diff(input int base, input logic [7:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i >= tx_log.size()) return i;
            if (tx_log[base + i] !== exp[i]) return i;
        end
        if (tx_log.size() != base + exp.size()) return exp.size();
        return -1;
    endfunction

    function automatic logic [7:0] log_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (rx_rd == rx_wr && !busy) done = 1'b1;
        end
        total_cnt++;
        if (!done) $display("FAIL %s_timeout: busy=%0b after 2000 cycles, want idle", name, busy);
        else pass_cnt++;
    endtask

    task automatic wait_log(input int count, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (tx_log.size() >= count) done = 1'b1;
        end
        total_cnt++;
        if (!done) $display("FAIL %s_timeout: %0d tx bytes, want %0d", name, tx_log.size(), count);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (uart_rx_read !== 1'b0) $display("FAIL rst_rx_read: got %0b want 0", uart_rx_read); else pass_cnt++;
        total_cnt++; if (uart_tx_start !== 1'b0) $display("FAIL rst_tx_start: got %0b want 0", uart_tx_start); else pass_cnt++;
        total_cnt++; if (uart_tx_data_in !== 8'h00) $display("FAIL rst_tx_data: got %02h want 00", uart_tx_data_in); else pass_cnt++;
        total_cnt++; if (line_len !== '0) $display("FAIL rst_line_len: got %0d want 0", line_len); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 16'h0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_raw();
        logic [7:0] exp[$];
        int base, p0, n, d;
        bit found;
        logic [7:0] first_data;
        mode = 2'd0;
        @(negedge clk);
        base = tx_log.size();
        p0 = rd_pulses;
        push(8'h41);
        n = 0;
        found = 1'b0;
        first_data = 8'h00;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (uart_tx_start) begin
                found = 1'b1;
                first_data = uart_tx_data_in;
            end
        end
        total_cnt++;
        if (!found || n - 1 != 4) $display("FAIL raw_latency: got %0d cycles (seen=%0b) want 4", n - 1, found);
        else pass_cnt++;
        total_cnt++;
        if (first_data !== 8'h41) $display("FAIL raw_first_data: got %02h want 41", first_data);
        else pass_cnt++;
        wait_idle("raw_a");
        push(8'h62);
        wait_idle("raw_b");
        exp = '{8'h41, 8'h62};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL raw_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
        total_cnt++;
        if (rd_pulses - p0 != 2) $display("FAIL raw_rx_reads: got %0d pulses want 2", rd_pulses - p0);
        else pass_cnt++;
    endtask

    task automatic test_upper();
        logic [7:0] exp[$];
        int base, d;
        mode = 2'd1;
        base = tx_log.size();
        push(8'h61); push(8'h5A); push(8'h7B); push(8'h60); push(8'h7A);
        wait_idle("upper");
        exp = '{8'h41, 8'h5A, 8'h7B, 8'h60, 8'h5A};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL upper_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
    endtask

    task automatic test_line_edit();
        logic [7:0] exp[$];
        int base, d;
        mode = 2'd2;
        base = tx_log.size();
        push(8'h7F); push(8'h0A); push(8'h61); push(8'h62); push(8'h08); push(8'h63); push(8'h0D);
        wait_idle("edit");
        exp = '{8'h61, 8'h62, 8'h08, 8'h20, 8'h08, 8'h63, 8'h0D, 8'h0A, 8'h61, 8'h63, 8'h0D, 8'h0A};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL edit_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
        total_cnt++;
        if (line_len !== '0) $display("FAIL edit_line_len: got %0d want 0", line_len);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        int base, d;
        base = tx_log.size();
        push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65);
        wait_idle("ovf_fill");
        exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h07};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL ovf_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
        total_cnt++;
        if (line_len !== LW'(4)) $display("FAIL ovf_line_len: got %0d want 4", line_len);
        else pass_cnt++;
        total_cnt++;
        if (drop_cnt !== 16'd1) $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt);
        else pass_cnt++;
        base = tx_log.size();
        push(8'h0D);
        wait_idle("ovf_replay");
        exp = '{8'h0D, 8'h0A, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL ovf_replay_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
        total_cnt++;
        if (line_len !== '0) $display("FAIL ovf_replay_len: got %0d want 0", line_len);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [7:0] exp[$];
        logic [15:0] pat;
        int base, d, s0, s1;
        bit done;
        push(8'h71); push(8'h72);
        wait_idle("stall_fill");
        base = tx_log.size();
        push(8'h0D);
        wait_log(base + 3, "stall_start");
        @(negedge clk);
        uart_tx_full = 1'b1;
        @(negedge clk);
        s0 = tx_log.size();
        repeat (48) @(negedge clk);
        s1 = tx_log.size();
        uart_tx_full = 1'b0;
        total_cnt++;
        if (s1 != s0) $display("FAIL stall_hold: got %0d starts while full want 0", s1 - s0);
        else pass_cnt++;
        wait_idle("stall_drain");
        exp = '{8'h0D, 8'h0A, 8'h71, 8'h72, 8'h0D, 8'h0A};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL stall_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;

        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        wait_idle("toggle_fill");
        base = tx_log.size();
        pat = 16'b1101_0011_1000_1110;
        push(8'h0D);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            uart_tx_full = pat[i % 16];
            #1;
            if (rx_rd == rx_wr && !busy) done = 1'b1;
        end
        uart_tx_full = 1'b0;
        total_cnt++;
        if (!done) $display("FAIL toggle_timeout: busy=%0b after 400 cycles, want idle", busy);
        else pass_cnt++;
        exp = '{8'h0D, 8'h0A, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL toggle_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
        total_cnt++;
        if (stall_viol != 0) $display("FAIL start_while_full: got %0d want 0", stall_viol);
        else pass_cnt++;
        total_cnt++;
        if (gap_viol != 0) $display("FAIL start_gap: got %0d back-to-back starts want 0", gap_viol);
        else pass_cnt++;
        total_cnt++;
        if (read_viol != 0) $display("FAIL read_width: got %0d long read pulses want 0", read_viol);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        int base, d;
        push(8'h70); push(8'h71); push(8'h72); push(8'h73);
        wait_idle("mid_fill");
        base = tx_log.size();
        push(8'h0D);
        wait_log(base + 4, "mid_replay");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++; if (uart_rx_read !== 1'b0) $display("FAIL mid_rx_read: got %0b want 0", uart_rx_read); else pass_cnt++;
        total_cnt++; if (uart_tx_start !== 1'b0) $display("FAIL mid_tx_start: got %0b want 0", uart_tx_start); else pass_cnt++;
        total_cnt++; if (uart_tx_data_in !== 8'h00) $display("FAIL mid_tx_data: got %02h want 00", uart_tx_data_in); else pass_cnt++;
        total_cnt++; if (line_len !== '0) $display("FAIL mid_line_len: got %0d want 0", line_len); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 16'h0) $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        base = tx_log.size();
        push(8'h78); push(8'h0D);
        wait_idle("mid_after");
        exp = '{8'h78, 8'h0D, 8'h0A, 8'h78, 8'h0D, 8'h0A};
        d = first_diff(base, exp);
        total_cnt++;
        if (d != -1) $display("FAIL mid_after_seq: byte %0d got %02h want %02h (got %0d bytes want %0d)",
                              d, log_at(base + d), (d < exp.size()) ? exp[d] : 8'hxx, tx_log.size() - base, exp.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_upper();
        test_line_edit();
        test_overflow();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
